intr_ctrl: RTL
==============

// Module: intr_ctrl
// PURPOSE
//  Interrupt front end for the multicycle OTTER core; sits directly upstream of the CSR file.
//  - Synchronises and edge-detects the async external IRQ pin.
//  - Counts un-serviced requests.
//  - Gates requests with CSR_ME, CSR_MTVEC and instruction boundaries.
//  - Issues the one-cycle INT_TAKEN strobe consumed by the CSR file.
//  - Supplies the trap/return PC redirect (MTVEC on entry, MEPC on mret) to the PC mux.
// PARAMETERS
//  SYNC_STAGES  2  flops in IRQ synchroniser chain (legal >= 2)
//  PEND_CNT_W   3  width of saturating pending-request counter
// PORTS
//  CLK             in   1           system clock, all state on posedge
//  RESET           in   1           synchronous, active-high reset
//  IRQ             in   1           async external interrupt request, level, rising edge = 1 request
//  CSR_ME          in   1           machine interrupt enable from CSR file
//  CSR_MTVEC       in   32          handler base from CSR file
//  CSR_MEPC        in   32          saved return PC from CSR file
//  INSTR_BOUNDARY  in   1           1-cycle pulse from control FSM: current instruction retired
//  MRET_EXEC       in   1           retiring instruction is mret (qualified by INSTR_BOUNDARY)
//  INT_TAKEN       out  1           1-cycle strobe to CSR file: save PC, clear ME
//  TRAP_PC_VALID   out  1           TRAP_PC must be loaded into PC this cycle
//  TRAP_PC         out  32          redirect target
//  IN_ISR          out  1           handler executing (entry taken, mret not yet retired)
//  IRQ_PENDING     out  1           PEND_CNT != 0
//  PEND_CNT        out  PEND_CNT_W  outstanding requests
// BEHAVIOUR
//  Reset (RESET=1 at posedge):
//  - Clears sync chain, edge flop, PEND_CNT; state -> IDLE.
//  - All outputs 0 from that edge.
//  - Reset during TAKE or ISR aborts it: no INT_TAKEN in the cycle after.
//  Edge detect:
//  - s[0] <= IRQ ... s[S-1] <= s[S-2]; p <= s[S-1]; rise = s[S-1] & ~p.
//  - IRQ high before posedge k gives rise during cycle k+S-1..k+S; count updates at posedge k+S.
//  - Held-high IRQ produces exactly one request; it must drop for >= 1 synchronised cycle to re-request.
//  PEND_CNT:
//  - +1 on rise, saturates at 2^PEND_CNT_W-1 (further edges dropped).
//  - -1 when state==TAKE.
//  - rise and TAKE in the same cycle: count unchanged.
//  - Edges are counted in every state, including ISR and while CSR_ME=0.
//  FSM (Moore INT_TAKEN):
//  - IDLE:
//    - Go to TAKE when INSTR_BOUNDARY & ~MRET_EXEC & CSR_ME & (PEND_CNT!=0) & (CSR_MTVEC!=0).
//    - CSR_MTVEC==0 means no handler installed: request stays pending, never taken.
//  - TAKE (exactly 1 cycle):
//    - INT_TAKEN=1, TRAP_PC_VALID=1, TRAP_PC={CSR_MTVEC[31:2],2'b00} (direct mode).
//    - Always -> ISR.
//    - Control FSM must hold PC stable (next-instruction PC) during TAKE.
//  - ISR:
//    - IN_ISR=1.
//    - On INSTR_BOUNDARY & MRET_EXEC -> IDLE.
//  mret redirect:
//  - Combinational, any state except TAKE.
//  - INSTR_BOUNDARY & MRET_EXEC drives TRAP_PC_VALID=1, TRAP_PC=CSR_MEPC (unmasked) in the same cycle.
//  - Stray mret in IDLE redirects but stays IDLE.
//  Re-entry:
//  - ME is cleared by the CSR file on INT_TAKEN; the handler must re-enable it.
//  - Leftover PEND_CNT is taken at the first qualifying boundary after returning to IDLE.
//  - No interrupt is taken on the same boundary as the mret.
//  - ISR never nests: TAKE is reachable only from IDLE.
//  Priority on the same boundary: mret redirect > interrupt entry.
//  Outside TAKE and mret redirect: TRAP_PC=0, TRAP_PC_VALID=0.
// TESTING
//  - Reset: RESET=1 for 2 cycles with IRQ=1 -> all outputs 0.
//    After release, PEND_CNT=1 at posedge S+1.
//  - Basic entry:
//    - Stimulus: ME=1, MTVEC=0x0000_0103, one IRQ pulse, boundary 5 cycles later.
//    - Response: next cycle INT_TAKEN=1, TRAP_PC=0x100, PEND_CNT 1->0, then IN_ISR=1.
//  - Gating: ME=0, or MTVEC=0, with 2 IRQ edges and repeated boundaries.
//    - Response: no INT_TAKEN, PEND_CNT=2.
//    - Set ME=1 and MTVEC!=0 -> taken at the next boundary.
//  - Return:
//    - Stimulus: in ISR, MEPC=0x0000_0040, boundary+MRET.
//    - Response: same cycle TRAP_PC_VALID=1, TRAP_PC=0x40; next cycle IN_ISR=0.
//  - Saturation and simultaneity (PEND_CNT_W=3):
//    - 9 edges -> PEND_CNT=7.
//    - Edge coincident with TAKE -> count unchanged.
//    - IRQ held high 20 cycles -> exactly +1.
//  - mret and IRQ on the same boundary with ME=1, pending:
//    - Response: redirect to MEPC, no INT_TAKEN.
//    - Interrupt taken at the following boundary.

Source files
------------

// File: rtl/intr_ctrl.sv
// Interrupt front end for the multicycle OTTER core.
// Synchronises and edge-detects the external IRQ pin, counts outstanding
// requests, decides when an interrupt may be entered on an instruction
// boundary, and supplies the trap/return PC redirect to the PC mux.
module intr_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_CNT_W  = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  IRQ,
  input  logic                  CSR_ME,
  input  logic [31:0]           CSR_MTVEC,
  input  logic [31:0]           CSR_MEPC,
  input  logic                  INSTR_BOUNDARY,
  input  logic                  MRET_EXEC,
  output logic                  INT_TAKEN,
  output logic                  TRAP_PC_VALID,
  output logic [31:0]           TRAP_PC,
  output logic                  IN_ISR,
  output logic                  IRQ_PENDING,
  output logic [PEND_CNT_W-1:0] PEND_CNT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAKE = 2'd1,
    ST_ISR  = 2'd2
  } state_e;

  localparam logic [PEND_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_CNT_W-1:0] CNT_ONE = PEND_CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   irq_rise;
  logic [PEND_CNT_W-1:0]  cnt_q, cnt_d;
  state_e                 state_q, state_d;
  logic                   in_take;
  logic                   mret_ret;
  logic                   entry_ok;

  assign irq_rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign in_take  = (state_q == ST_TAKE);
  assign mret_ret = INSTR_BOUNDARY & MRET_EXEC;
  assign entry_ok = INSTR_BOUNDARY & ~MRET_EXEC & CSR_ME &
                    (cnt_q != '0) & (CSR_MTVEC != '0);

  // Synchroniser chain plus the previous-sample flop used for edge detection.
  // NOTE: clocked state is always assigned with <= so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], IRQ};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Pending-request counter: saturating increment on a rise, decrement on entry.
  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (irq_rise && in_take) begin
      cnt_d = cnt_q;
    end else if (irq_rise) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
    end else if (in_take) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Counter and FSM state registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q   <= '0;
      state_q <= ST_IDLE;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Next-state logic: entry only from IDLE, TAKE lasts one cycle, mret leaves ISR.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (entry_ok) state_d = ST_TAKE;
      ST_TAKE: state_d = ST_ISR;
      ST_ISR:  if (mret_ret) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: Moore strobes from state, mret redirect straight from inputs.
  always_comb begin
    INT_TAKEN     = in_take;
    IN_ISR        = (state_q == ST_ISR);
    IRQ_PENDING   = (cnt_q != '0);
    PEND_CNT      = cnt_q;
    TRAP_PC_VALID = 1'b0;
    TRAP_PC       = '0;
    if (in_take) begin
      TRAP_PC_VALID = 1'b1;
      TRAP_PC       = {CSR_MTVEC[31:2], 2'b00};
    end else if (mret_ret) begin
      TRAP_PC_VALID = 1'b1;
      TRAP_PC       = CSR_MEPC;
    end
  end

endmodule
